stream_demux2: RTL
==================

Name:
stream_demux2

Overview:
- Registered 1-to-2 steering demultiplexer. It is the opposite direction of the team's 2:1 select mux (z = c ? b : a).
- Takes one valid/ready input stream plus a select bit, and delivers each accepted word to output channel 0 or channel 1.
- Each channel has its own FIFO, so back-pressure on one channel does not corrupt or reorder words on the other.
- Sits between the CPU datapath result bus and two downstream consumers (e.g. register write-back and store path).

Parameters:
- WIDTH, 32, data word width in bits.
- DEPTH, 2, entries per channel FIFO. Must be a power of 2 and ≥ 2.
- CW, $clog2(DEPTH)+1, width of the occupancy counters (derived parameter; not overridden).

Ports:
- clk  input  1  rising-edge clock.
- reset  input  1  asynchronous, active-high reset.
- in_valid  input  1  input word present.
- in_ready  output  1  block can accept the input word this cycle.
- in_sel  input  1  destination: 0 selects channel 0, 1 selects channel 1. Qualified by in_valid.
- in_data  input  WIDTH  input word.
- out0_valid  output  1  channel 0 has a word.
- out0_ready  input  1  channel 0 consumer accepts.
- out0_data  output  WIDTH  channel 0 head word.
- out1_valid  output  1  channel 1 has a word.
- out1_ready  input  1  channel 1 consumer accepts.
- out1_data  output  WIDTH  channel 1 head word.
- out0_count  output  CW  channel 0 occupancy.
- out1_count  output  CW  channel 1 occupancy.

Behaviour:
- One clock domain. Reset is asynchronous and active-high. All state is cleared immediately when reset asserts, independent of clk.
- Reset values:
  - counts = 0, read and write pointers = 0, storage = 0.
  - out0_valid = out1_valid = 0, out0_data = out1_data = 0.
  - out0_count = out1_count = 0.
  - in_ready = 1 (both channels empty).
- Reset mid-operation: all in-flight words are discarded. No word may appear on an output after reset without a new accept.
- Input handshake:
  - in_ready = NOT full[in_sel]. This is combinational from in_sel and the registered counts only; it never depends on outN_ready (no full-FIFO pass-through).
  - A word is accepted when in_valid AND in_ready at the rising edge. It is written at wr_ptr[in_sel]; that wr_ptr increments modulo DEPTH.
- Output handshake, per channel N:
  - outN_valid = (countN != 0). outN_data = storage[rd_ptrN].
  - A pop occurs when outN_valid AND outN_ready at the edge; rd_ptrN increments modulo DEPTH.
  - outN_valid must hold and outN_data must stay stable until popped.
- Latency: a word accepted at edge k is visible on outN_valid/outN_data after edge k (1-cycle latency). There is no combinational in→out path.
- Occupancy per channel:
  - push only: count + 1.
  - pop only: count − 1.
  - push and pop in the same cycle: count unchanged, pointers both advance.
- Boundaries:
  - Full (count = DEPTH): in_ready = 0 for that sel. A simultaneous pop does not make in_ready high in the same cycle; it rises the next cycle.
  - Empty: outN_ready has no effect; count never underflows.
  - Pointer wrap from DEPTH−1 to 0 is seamless.
  - in_sel toggling while in_valid = 0 has no effect on state.
- Ordering: words on each channel leave in acceptance order. No ordering is defined between channels.
- Channel independence: a stall on one channel never blocks the other when in_sel targets the non-full channel.

Test Plan:
- Reset then idle → in_ready = 1, both valid = 0, counts = 0, data = 0. Assert reset asynchronously between edges → outputs clear before the next edge.
- DEPTH = 2; push 0xA1, 0xA2 to sel 0 with out0_ready = 0 → out0_count = 2, in_ready = 0 for sel 0, in_ready = 1 for sel 1. Push 0xB1 to sel 1 → out1_valid = 1, out1_data = 0xB1.
- Raise out0_ready for 2 cycles → out0_data = 0xA1 then 0xA2, out0_valid = 0 afterward, count returns to 0.
- Alternate sel 0,1,0,1 with data 1..4, both readies = 1 → ch0 emits 1,3 and ch1 emits 2,4, each one cycle after accept. Counts never exceed 1.
- Full channel 0, then pop and offer a push to sel 0 in the same cycle → push refused (in_ready = 0); count = 1 next cycle and in_ready = 1. Then push and pop together at count = 1 → count stays 1 and order is preserved.
- Fill channel 1 with 0x11, 0x22, apply reset for half a cycle, release → out1_valid = 0. A new push of 0x33 → out1_data = 0x33 (no stale 0x11).

Source files
------------

// File: rtl/stream_demux2.sv
// stream_demux2: registered 1-to-2 steering demultiplexer.
// Each word accepted on the input stream is written into the FIFO of the
// channel picked by in_sel. Each channel drains independently, so a stalled
// consumer on one channel never reorders or corrupts the other.
//
// Ports:
//   clk, reset               rising-edge clock, asynchronous active-high reset
//   in_valid/in_ready        input handshake; in_ready = channel[in_sel] not full
//   in_sel                   destination channel (qualified by in_valid)
//   in_data                  input word
//   out0_valid/out0_ready    channel 0 handshake, out0_data = channel 0 head word
//   out1_valid/out1_ready    channel 1 handshake, out1_data = channel 1 head word
//   out0_count, out1_count   per-channel occupancy (0..DEPTH)
module stream_demux2 #(
  parameter int unsigned WIDTH = 32,
  parameter int unsigned DEPTH = 2,
  localparam int unsigned CW = $clog2(DEPTH) + 1
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic             in_sel,
  input  logic [WIDTH-1:0] in_data,
  output logic             out0_valid,
  input  logic             out0_ready,
  output logic [WIDTH-1:0] out0_data,
  output logic             out1_valid,
  input  logic             out1_ready,
  output logic [WIDTH-1:0] out1_data,
  output logic [CW-1:0]    out0_count,
  output logic [CW-1:0]    out1_count
);

  localparam int unsigned PW = $clog2(DEPTH);

  logic [WIDTH-1:0] mem_q    [2][DEPTH];
  logic [PW-1:0]    wr_ptr_q [2];
  logic [PW-1:0]    rd_ptr_q [2];
  logic [CW-1:0]    count_q  [2];

  logic [1:0] full;
  logic [1:0] push;
  logic [1:0] pop;

  assign out0_valid = (count_q[0] != '0);
  assign out1_valid = (count_q[1] != '0);
  assign out0_data  = mem_q[0][rd_ptr_q[0]];
  assign out1_data  = mem_q[1][rd_ptr_q[1]];
  assign out0_count = count_q[0];
  assign out1_count = count_q[1];

  // in_ready looks only at registered occupancy: a pop in the same cycle
  // does not free a slot until the next cycle.
  always_comb begin
    full[0]  = (count_q[0] == CW'(DEPTH));
    full[1]  = (count_q[1] == CW'(DEPTH));
    in_ready = ~full[in_sel];
    push     = 2'b00;
    if (in_valid && in_ready) begin
      push[in_sel] = 1'b1;
    end
    pop[0] = out0_valid & out0_ready;
    pop[1] = out1_valid & out1_ready;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int n = 0; n < 2; n++) begin
        wr_ptr_q[n] <= '0;
        rd_ptr_q[n] <= '0;
        count_q[n]  <= '0;
        for (int i = 0; i < DEPTH; i++) begin
          mem_q[n][i] <= '0;
        end
      end
    end else begin
      for (int n = 0; n < 2; n++) begin
        if (push[n]) begin
          mem_q[n][wr_ptr_q[n]] <= in_data;
          // DEPTH is a power of two, so natural pointer overflow wraps cleanly
          wr_ptr_q[n] <= wr_ptr_q[n] + PW'(1);
        end
        if (pop[n]) begin
          rd_ptr_q[n] <= rd_ptr_q[n] + PW'(1);
        end
        case ({push[n], pop[n]})
          2'b10:   count_q[n] <= count_q[n] + CW'(1);
          2'b01:   count_q[n] <= count_q[n] - CW'(1);
          default: count_q[n] <= count_q[n];
        endcase
      end
    end
  end

endmodule
